pending_event_multi: RTL and testbench

- Multi-channel, frame-aligned input event limiter for the Tetris control path.
- Sits between per-button edge detectors and the game FSM.
- Per channel, it queues up to DEPTH presses that arrive between tick_input pulses, and emits at most one 1-clock button pulse per channel per input frame.
- Adds optional hold-to-repeat (delayed auto shift) and a one-action-per-frame arbitration mode.

---
 rtl/pending_event_multi_pkg.sv | 23 ++
 rtl/pending_event_multi_if.sv | 24 ++
 rtl/pending_event_multi_chan.sv | 105 ++++++++++
 rtl/pending_event_multi.sv | 90 +++++++++
 tb/tb_pending_event_multi.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pending_event_multi_pkg.sv
// Shared constants and helpers for the Tetris input-path event limiter.
package tetris_input_pkg;

  localparam int MODE_PARALLEL  = 0;
  localparam int MODE_EXCLUSIVE = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_phase_e;

  // Never returns less than 1 so single-entry counters and pointers keep a bit.
  function automatic int clog2_sat(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pending_event_multi_if.sv
// Button-side bundle of the event limiter: press inputs in, frame-aligned actions out.
interface pending_event_multi_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] edge_1clk;
  logic [N_CH-1:0] level;
  logic            tick_input;
  logic            clr_ovf;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overflow;

  modport master (
    output edge_1clk, level, tick_input, clr_ovf,
    input  button, pending, overflow
  );

  modport slave (
    input  edge_1clk, level, tick_input, clr_ovf,
    output button, pending, overflow
  );

endinterface

// File: rtl/pending_event_multi_chan.sv
// One button channel: saturating press queue, sticky overflow flag and
// hold-to-repeat phase/timer that injects presses on input ticks.
module pending_event_chan
  import tetris_input_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 2,
  parameter bit REPEAT_EN = 1'b0,
  parameter int DAS       = 10,
  parameter int ARR       = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic edge_i,
  input  logic level_i,
  input  logic tick_i,
  input  logic clr_ovf_i,
  input  logic fire_i,
  output logic eligible_o,
  output logic pending_o,
  output logic overflow_o
);

  localparam int T_MAX = (DAS > ARR) ? DAS : ARR;
  localparam int TMR_W = clog2_sat(T_MAX + 1);
  localparam int SUM_W = CNT_W + 1;

  rep_phase_e       phase_q, phase_d;
  logic [TMR_W-1:0] timer_q, timer_d, timerInc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntNext;
  logic [SUM_W-1:0] cntSum;
  logic             ovf_q, ovf_d;
  logic             repInj;
  logic             lost;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Release beats a new press, which beats tick-driven timer progress.
  always_comb begin
    phase_d  = phase_q;
    timer_d  = timer_q;
    repInj   = 1'b0;
    timerInc = timer_q + 1'b1;
    if (!REPEAT_EN || !level_i) begin
      phase_d = IDLE;
      timer_d = '0;
    end else if (edge_i) begin
      phase_d = DELAY;
      timer_d = '0;
    end else if (tick_i) begin
      case (phase_q)
        DELAY: begin
          if (timerInc == TMR_W'(DAS)) begin
            repInj  = (cnt_q == '0);
            phase_d = REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timerInc;
          end
        end
        REPEAT: begin
          if (timerInc == TMR_W'(ARR)) begin
            repInj  = (cnt_q == '0);
            timer_d = '0;
          end else begin
            timer_d = timerInc;
          end
        end
        default: begin
          phase_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cntSum  = SUM_W'(cnt_q) + SUM_W'(edge_i) + SUM_W'(repInj);
    lost    = 1'b0;
    cntNext = cntSum[CNT_W-1:0];
    if (cntSum > SUM_W'(DEPTH)) begin
      cntNext = CNT_W'(DEPTH);
      lost    = 1'b1;
    end
    cnt_d = cntNext - CNT_W'(fire_i);
    ovf_d = (ovf_q & ~clr_ovf_i) | lost;
  end

  assign eligible_o = (cntNext != '0);
  assign pending_o  = (cnt_q != '0);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/pending_event_multi.sv
// Frame-aligned multi-channel press limiter: per-channel queues plus the
// tick-time fire decision (parallel or round-robin exclusive) and button register.
module pending_event_multi
  import tetris_input_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              DEPTH       = 2,
  parameter int              MODE        = MODE_PARALLEL,
  parameter logic [N_CH-1:0] REPEAT_MASK = N_CH'(4'b0011),
  parameter int              DAS         = 10,
  parameter int              ARR         = 3
) (
  input logic                  clock,
  input logic                  resetn,
  pending_event_multi_if.slave bus
);

  localparam int CNT_W = clog2_sat(DEPTH + 1);
  localparam int PTR_W = clog2_sat(N_CH);
  localparam int PW1   = PTR_W + 1;

  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  fire;
  logic [N_CH-1:0]  pendingVec;
  logic [N_CH-1:0]  overflowVec;
  logic [N_CH-1:0]  button_q;
  logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0] rrIdx;
  logic [PW1-1:0]   rrSum;
  logic             grantFound;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pending_event_chan #(
      .DEPTH     (DEPTH),
      .CNT_W     (CNT_W),
      .REPEAT_EN (REPEAT_MASK[i]),
      .DAS       (DAS),
      .ARR       (ARR)
    ) u_chan (
      .clock      (clock),
      .resetn     (resetn),
      .edge_i     (bus.edge_1clk[i]),
      .level_i    (bus.level[i]),
      .tick_i     (bus.tick_input),
      .clr_ovf_i  (bus.clr_ovf),
      .fire_i     (fire[i]),
      .eligible_o (eligible[i]),
      .pending_o  (pendingVec[i]),
      .overflow_o (overflowVec[i])
    );
  end

  // Scan from rr_ptr with wrap; the pointer only moves on a granted tick.
  always_comb begin
    grant      = '0;
    grantFound = 1'b0;
    rrPtr_d    = rrPtr_q;
    rrSum      = '0;
    rrIdx      = '0;
    for (int k = 0; k < N_CH; k++) begin
      rrSum = {1'b0, rrPtr_q} + PW1'(k);
      if (rrSum >= PW1'(N_CH)) rrSum = rrSum - PW1'(N_CH);
      rrIdx = rrSum[PTR_W-1:0];
      if (!grantFound && eligible[rrIdx]) begin
        grantFound   = 1'b1;
        grant[rrIdx] = 1'b1;
        rrPtr_d      = (rrIdx == PTR_W'(N_CH - 1)) ? '0 : rrIdx + 1'b1;
      end
    end
    fire = '0;
    if (bus.tick_input) fire = (MODE == MODE_EXCLUSIVE) ? grant : eligible;
    if (!bus.tick_input || (MODE != MODE_EXCLUSIVE)) rrPtr_d = rrPtr_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      button_q <= '0;
      rrPtr_q  <= '0;
    end else begin
      button_q <= fire;
      rrPtr_q  <= rrPtr_d;
    end
  end

  assign bus.button   = button_q;
  assign bus.pending  = pendingVec;
  assign bus.overflow = overflowVec;

endmodule

// File: tb/tb_pending_event_multi.sv
// Bench for pending_event_multi: a parallel and an exclusive instance share stimulus
// and are compared every cycle against a countdown-based reference model.
module tb_pending_event_multi;
  import tetris_input_pkg::*;

  localparam int             NCH   = 4;
  localparam int             DEPTH = 2;
  localparam int             DAS   = 10;
  localparam int             ARR   = 3;
  localparam logic [NCH-1:0] RMASK = 4'b0011;

  logic clock  = 1'b0;
  logic resetn = 1'b1;

  pending_event_multi_if #(.N_CH(NCH)) busPar ();
  pending_event_multi_if #(.N_CH(NCH)) busExc ();

  pending_event_multi #(
    .N_CH(NCH), .DEPTH(DEPTH), .MODE(MODE_PARALLEL),
    .REPEAT_MASK(RMASK), .DAS(DAS), .ARR(ARR)
  ) dutPar (
    .clock  (clock),
    .resetn (resetn),
    .bus    (busPar)
  );

  pending_event_multi #(
    .N_CH(NCH), .DEPTH(DEPTH), .MODE(MODE_EXCLUSIVE),
    .REPEAT_MASK(RMASK), .DAS(DAS), .ARR(ARR)
  ) dutExc (
    .clock  (clock),
    .resetn (resetn),
    .bus    (busExc)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue length, "held and armed" flag with a tick countdown.
  int             mCount[2][NCH];
  bit             mArmed[2][NCH];
  int             mCd[2][NCH];
  bit             mOvf[2][NCH];
  int             mRr[2];
  logic [NCH-1:0] mBtn[2];

  typedef struct {
    logic [NCH-1:0] edgeIn;
    logic [NCH-1:0] levelIn;
    logic           tickIn;
    logic           clrIn;
    logic [NCH-1:0] expButton;
    logic [NCH-1:0] expPending;
    logic [NCH-1:0] expOverflow;
  } vector_t;

  vector_t vectors[18];

  task automatic resetModel();
    for (int m = 0; m < 2; m++) begin
      mRr[m]  = 0;
      mBtn[m] = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        mCount[m][ch] = 0;
        mArmed[m][ch] = 1'b0;
        mCd[m][ch]    = 0;
        mOvf[m][ch]   = 1'b0;
      end
    end
  endtask

  task automatic modelStep(input int m, input logic [NCH-1:0] e, input logic [NCH-1:0] lv,
                           input logic t, input logic c);
    int  nxt[NCH];
    bit  fireV[NCH];
    bit  inj;
    bit  found;
    int  total;
    int  idx;
    for (int ch = 0; ch < NCH; ch++) begin
      inj = 1'b0;
      if (!RMASK[ch] || !lv[ch]) begin
        mArmed[m][ch] = 1'b0;
      end else if (e[ch]) begin
        mArmed[m][ch] = 1'b1;
        mCd[m][ch]    = DAS;
      end else if (t && mArmed[m][ch]) begin
        mCd[m][ch] = mCd[m][ch] - 1;
        if (mCd[m][ch] == 0) begin
          inj        = (mCount[m][ch] == 0);
          mCd[m][ch] = ARR;
        end
      end
      total = mCount[m][ch] + int'(e[ch]) + int'(inj);
      if (total > DEPTH) begin
        nxt[ch]     = DEPTH;
        mOvf[m][ch] = 1'b1;
      end else begin
        nxt[ch] = total;
        if (c) mOvf[m][ch] = 1'b0;
      end
      fireV[ch] = 1'b0;
    end
    if (t) begin
      if (m == 0) begin
        for (int ch = 0; ch < NCH; ch++) fireV[ch] = (nxt[ch] != 0);
      end else begin
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          idx = (mRr[m] + k) % NCH;
          if (!found && nxt[idx] != 0) begin
            found      = 1'b1;
            fireV[idx] = 1'b1;
            mRr[m]     = (idx + 1) % NCH;
          end
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      mCount[m][ch] = nxt[ch] - int'(fireV[ch]);
      mBtn[m][ch]   = fireV[ch];
    end
  endtask

  task automatic checkOutput(input string name, input logic [NCH-1:0] act,
                             input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [NCH-1:0] pend[2];
    logic [NCH-1:0] ovf[2];
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        pend[m][ch] = (mCount[m][ch] != 0);
        ovf[m][ch]  = mOvf[m][ch];
      end
    end
    checkOutput({tag, " par button"},   busPar.button,   mBtn[0]);
    checkOutput({tag, " par pending"},  busPar.pending,  pend[0]);
    checkOutput({tag, " par overflow"}, busPar.overflow, ovf[0]);
    checkOutput({tag, " exc button"},   busExc.button,   mBtn[1]);
    checkOutput({tag, " exc pending"},  busExc.pending,  pend[1]);
    checkOutput({tag, " exc overflow"}, busExc.overflow, ovf[1]);
  endtask

  task automatic driveInputs(input logic [NCH-1:0] e, input logic [NCH-1:0] lv,
                             input logic t, input logic c);
    busPar.edge_1clk  = e;
    busPar.level      = lv;
    busPar.tick_input = t;
    busPar.clr_ovf    = c;
    busExc.edge_1clk  = e;
    busExc.level      = lv;
    busExc.tick_input = t;
    busExc.clr_ovf    = c;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] e, input logic [NCH-1:0] lv,
                               input logic t, input logic c);
    driveInputs(e, lv, t, c);
    @(posedge clock);
    modelStep(0, e, lv, t, c);
    modelStep(1, e, lv, t, c);
    #1;
    checkAll("cycle");
  endtask

  task automatic doReset();
    driveInputs('0, '0, 1'b0, 1'b0);
    resetn = 1'b0;
    resetModel();
    repeat (2) @(posedge clock);
    #1;
    checkAll("reset");
    #1 resetn = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] expBtn;
    logic [NCH-1:0] lv;
    logic [NCH-1:0] e;

    vectors[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000};
    vectors[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000};
    vectors[2]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001};
    vectors[3]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001};
    vectors[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001};
    vectors[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0001};
    vectors[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001};
    vectors[7]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0001};
    vectors[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001};
    vectors[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    vectors[10] = '{4'b1100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1100, 4'b0000};
    vectors[11] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b1100, 4'b0100, 4'b0000};
    vectors[12] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0000};
    vectors[13] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0100};
    vectors[14] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0000};
    vectors[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000};
    vectors[16] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000};
    vectors[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000};

    $display("[TB] reset and parallel vector table");
    doReset();
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vectors[v].edgeIn, vectors[v].levelIn, vectors[v].tickIn, vectors[v].clrIn);
      checkOutput($sformatf("table %0d button", v),   busPar.button,   vectors[v].expButton);
      checkOutput($sformatf("table %0d pending", v),  busPar.pending,  vectors[v].expPending);
      checkOutput($sformatf("table %0d overflow", v), busPar.overflow, vectors[v].expOverflow);
    end

    $display("[TB] exclusive round-robin sequence");
    doReset();
    applyStimulus(4'b1101, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("rr grant 1", busExc.button, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("rr grant 2", busExc.button, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("rr grant 3", busExc.button, 4'b1000);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
    checkOutput("rr wrap to 0", busExc.button, 4'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("rr next ch1", busExc.button, 4'b0010);

    $display("[TB] auto-repeat hold on ch0");
    doReset();
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(4'b0000, 4'b0001, 1'b1, 1'b0);
      expBtn = (k == 1 || k == 10 || k == 13 || k == 16 || k == 19) ? 4'b0001 : 4'b0000;
      checkOutput($sformatf("repeat tick %0d par", k), busPar.button, expBtn);
      checkOutput($sformatf("repeat tick %0d exc", k), busExc.button, expBtn);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
      checkOutput($sformatf("released tick %0d", k), busPar.button, 4'b0000);
    end

    $display("[TB] asynchronous reset mid-delay");
    doReset();
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    checkOutput("async rst par pending",  busPar.pending,  4'b0000);
    checkOutput("async rst par overflow", busPar.overflow, 4'b0000);
    checkOutput("async rst par button",   busPar.button,   4'b0000);
    checkOutput("async rst exc pending",  busExc.pending,  4'b0000);
    checkOutput("async rst exc overflow", busExc.overflow, 4'b0000);
    resetModel();
    @(posedge clock);
    #2 resetn = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(4'b0000, 4'b0001, 1'b1, 1'b0);
      checkOutput($sformatf("post reset tick %0d", k), busPar.button, 4'b0000);
    end
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    checkOutput("post reset new edge", busPar.button, 4'b0001);

    $display("[TB] randomized traffic, dense presses");
    doReset();
    lv = '0;
    for (int n = 0; n < 300; n++) begin
      e = NCH'($urandom) & NCH'($urandom);
      for (int ch = 0; ch < NCH; ch++) if ($urandom_range(0, 11) == 0) lv[ch] = ~lv[ch];
      applyStimulus(e, lv, ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] randomized traffic, sparse presses with holds");
    for (int n = 0; n < 400; n++) begin
      e = NCH'($urandom) & NCH'($urandom) & NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
      for (int ch = 0; ch < NCH; ch++) if ($urandom_range(0, 39) == 0) lv[ch] = ~lv[ch];
      applyStimulus(e, lv, ($urandom_range(0, 1) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
